// File: rtl/dnn_pkg.sv
// Constants and FSM state type shared by the weight loader and the weight bank.
package dnn_pkg;
  localparam int N     = 40;
  localparam int NDATA = 24;
  localparam int NADDR = 9;
  localparam int LANE_W = $clog2(N);

  localparam logic [NADDR:0] MAX_ROWS = {1'b1, {NADDR{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } load_state_e;

  // A load can never cover more rows than the bank holds.
  function automatic logic [NADDR:0] clamp_rows(input logic [NADDR:0] n);
    return (n > MAX_ROWS) ? MAX_ROWS : n;
  endfunction
endpackage

// File: rtl/weight_loader_if.sv
// Valid/ready weight stream feeding the loader.
interface weight_loader_if;
  logic [dnn_pkg::NDATA-1:0] s_data;
  logic                      s_valid;
  logic                      s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/weight_loader_packer.sv
// Collects N consecutive weights into one row-wide stage register.
module weight_packer
  import dnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               run,
  input  logic               issue,
  input  logic [NDATA-1:0]   s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [N*NDATA-1:0] stage,
  output logic               stage_full
);
  logic [LANE_W-1:0]  lane_cnt_q, lane_cnt_d;
  logic               stage_full_q, stage_full_d;
  logic [N*NDATA-1:0] stage_q, stage_d;
  logic               xfer;

  always_comb begin
    s_ready      = run && !stage_full_q;
    xfer         = s_valid && s_ready;
    lane_cnt_d   = lane_cnt_q;
    stage_full_d = stage_full_q;
    stage_d      = stage_q;
    if (issue) stage_full_d = 1'b0;
    if (xfer) begin
      stage_d[lane_cnt_q*NDATA +: NDATA] = s_data;
      if (lane_cnt_q == LANE_W'(N-1)) begin
        lane_cnt_d   = '0;
        stage_full_d = 1'b1;
      end else begin
        lane_cnt_d = lane_cnt_q + 1'b1;
      end
    end
    // A new load discards any partially packed row.
    if (clear) begin
      lane_cnt_d   = '0;
      stage_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt_q   <= '0;
      stage_full_q <= 1'b0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      stage_full_q <= stage_full_d;
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign stage      = stage_q;
  assign stage_full = stage_full_q;
endmodule

// File: rtl/weight_loader.sv
// Packs the weight stream into rows and writes them to the bank, holding each
// row N cycles so the bank's per-lane delayed enables see stable data.
module weight_loader
  import dnn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [NADDR:0]     nrows,
  weight_loader_if.slave     s,
  output logic [N*NDATA-1:0] out,
  output logic [NADDR-1:0]   wraddr,
  output logic               wren,
  output logic               busy,
  output logic               done
);
  load_state_e        state_q, state_d;
  logic [NADDR:0]     nrows_q, nrows_d;
  logic [NADDR-1:0]   row_cnt_q, row_cnt_d;
  logic [LANE_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               hold_active_q, hold_active_d;
  logic [N*NDATA-1:0] out_q, out_d;
  logic [NADDR-1:0]   wraddr_q, wraddr_d;
  logic               wren_q, wren_d;
  logic               done_q, done_d;

  logic               start, run, issue, hold_end, hold_free, last_row, drain_done;
  logic [N*NDATA-1:0] stage;
  logic               stage_full;

  weight_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .run        (run),
    .issue      (issue),
    .s_data     (s.s_data),
    .s_valid    (s.s_valid),
    .s_ready    (s.s_ready),
    .stage      (stage),
    .stage_full (stage_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = (clamp_rows(nrows) == '0) ? DRAIN : RUN;
      RUN:     if (issue && last_row) state_d = DRAIN;
      DRAIN:   if (hold_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The hold window ending this cycle frees the bank for the next issue, so
  // back-to-back rows can land exactly N cycles apart.
  always_comb begin
    start      = (state_q == IDLE) && load_start;
    run        = (state_q == RUN);
    busy       = (state_q != IDLE);
    hold_end   = hold_active_q && (hold_cnt_q == LANE_W'(N-1));
    hold_free  = !hold_active_q || hold_end;
    issue      = run && stage_full && hold_free;
    last_row   = ({1'b0, row_cnt_q} + 1'b1) == nrows_q;
    drain_done = (state_q == DRAIN) && hold_free;
  end

  always_comb begin
    nrows_d       = start ? clamp_rows(nrows) : nrows_q;
    row_cnt_d     = row_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    hold_active_d = hold_active_q;
    out_d         = out_q;
    wraddr_d      = wraddr_q;
    wren_d        = issue;
    done_d        = drain_done;
    if (start) row_cnt_d = '0;
    if (issue) begin
      out_d         = stage;
      wraddr_d      = row_cnt_q;
      row_cnt_d     = row_cnt_q + 1'b1;
      hold_cnt_d    = '0;
      hold_active_d = 1'b1;
    end else if (hold_end) begin
      hold_cnt_d    = '0;
      hold_active_d = 1'b0;
    end else if (hold_active_q) begin
      hold_cnt_d    = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nrows_q       <= '0;
      row_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      hold_active_q <= 1'b0;
      out_q         <= '0;
      wraddr_q      <= '0;
      wren_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      nrows_q       <= nrows_d;
      row_cnt_q     <= row_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      hold_active_q <= hold_active_d;
      out_q         <= out_d;
      wraddr_q      <= wraddr_d;
      wren_q        <= wren_d;
      done_q        <= done_d;
    end
  end

  assign out    = out_q;
  assign wraddr = wraddr_q;
  assign wren   = wren_q;
  assign done   = done_q;
endmodule
